cache_ctrl_2way: RTL

// Sequencer for a 2-way set-associative, write-through, no-write-allocate byte cache.

---
 rtl/cache_ctrl_2way_pkg.sv | 32 +++
 rtl/cache_ctrl_2way_lru.sv | 47 ++++
 rtl/cache_ctrl_2way.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_2way_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_2way_pkg
// Shared definitions for the 2-way set-associative byte-cache sequencer:
// FSM state encodings, tag-word layout and tag-word helper functions.
// ---------------------------------------------------------------------------
package cache_ctrl_2way_pkg;

    // Sequencer states
    localparam logic [3:0] ST_INIT    = 4'd0;
    localparam logic [3:0] ST_IDLE    = 4'd1;
    localparam logic [3:0] ST_LOOKUP  = 4'd2;
    localparam logic [3:0] ST_COMPARE = 4'd3;
    localparam logic [3:0] ST_MEM_RD  = 4'd4;
    localparam logic [3:0] ST_FILL    = 4'd5;
    localparam logic [3:0] ST_UPDATE  = 4'd6;
    localparam logic [3:0] ST_MEM_WR  = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    // Tag word: bit 7 = valid, bits 6:0 = tag, LSB-aligned, zero padded
    localparam int VALID_BIT = 7;

    // Build a valid tag word from a zero-extended tag
    function automatic logic [7:0] tag_word(input logic [6:0] tag);
        return {1'b1, tag};
    endfunction

    // A way hits when its stored word is valid and the tag field matches
    function automatic logic tag_hit(input logic [7:0] word, input logic [6:0] tag);
        return word[VALID_BIT] && (word[6:0] == tag);
    endfunction

endpackage

// File: rtl/cache_ctrl_2way_lru.sv
// ---------------------------------------------------------------------------
// cache_ctrl_2way_lru
// One replacement bit per set; bit value = way to evict next in that set.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears to 0)
//   rd_idx / rd_way   combinational read of the bit for a set
//   upd_en/idx/way    registered update of one set's bit
// ---------------------------------------------------------------------------
module cache_ctrl_2way_lru #(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_way,
    input  logic               upd_en,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_way
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0] lru_q;
    logic [SETS-1:0] lru_d;

    assign rd_way = lru_q[rd_idx];

    // Next-state for the replacement bits
    always_comb begin
        lru_d = lru_q;
        if (upd_en) begin
            lru_d[upd_idx] = upd_way;
        end else begin
            lru_d = lru_q;
        end
    end

    // Replacement bit storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

endmodule

// File: rtl/cache_ctrl_2way.sv
// ---------------------------------------------------------------------------
// cache_ctrl_2way
// Sequencer for a 2-way set-associative, write-through, no-write-allocate
// byte cache. Drives four external negedge RAMs (tag+data per way), serves
// one CPU requester and uses a req/ack backing-memory port for read misses
// and all writes. Tag RAMs are cleared one set per cycle after reset.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cpu_req/we/addr/wdata            CPU request (sampled while cpu_ready)
//   cpu_ready/done/hit/rdata         CPU status and read result
//   ram_addr, ram_r_en               shared RAM address / read enable
//   tag_w_en, dat_w_en               per-way write enables
//   tag_wdata, dat_wdata             RAM write data
//   tag_rdata0/1, dat_rdata0/1       RAM read data per way
//   mem_req/we/addr/wdata            backing-memory request
//   mem_rdata, mem_ack               backing-memory response
// ---------------------------------------------------------------------------
module cache_ctrl_2way
    import cache_ctrl_2way_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ready,
    output logic       cpu_done,
    output logic       cpu_hit,
    output logic [7:0] cpu_rdata,
    output logic [7:0] ram_addr,
    output logic       ram_r_en,
    output logic [1:0] tag_w_en,
    output logic [1:0] dat_w_en,
    output logic [7:0] tag_wdata,
    output logic [7:0] dat_wdata,
    input  logic [7:0] tag_rdata0,
    input  logic [7:0] tag_rdata1,
    input  logic [7:0] dat_rdata0,
    input  logic [7:0] dat_rdata1,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack
);

    localparam int PAD_W = 8 - INDEX_W;

    logic [3:0]         state_q,     state_d;
    logic [INDEX_W-1:0] init_cnt_q,  init_cnt_d;
    logic               req_we_q,    req_we_d;
    logic [7:0]         req_addr_q,  req_addr_d;
    logic [7:0]         req_wdata_q, req_wdata_d;
    logic               hit_way_q,   hit_way_d;
    logic [1:0]         valid_q,     valid_d;
    logic [7:0]         fill_data_q, fill_data_d;
    logic               res_hit_q,   res_hit_d;
    logic [7:0]         res_data_q,  res_data_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               cpu_done_q,  cpu_done_d;
    logic               cpu_hit_q,   cpu_hit_d;
    logic [7:0]         cpu_rdata_q, cpu_rdata_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [7:0]         mem_addr_q,  mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;

    logic [INDEX_W-1:0] req_idx_s;
    logic [6:0]         req_tag_s;
    logic               hit0_s;
    logic               hit1_s;
    logic               victim_s;
    logic               lru_way_s;
    logic               lru_upd_en_s;
    logic               lru_upd_way_s;

    assign req_idx_s = req_addr_q[INDEX_W-1:0];
    assign req_tag_s = 7'(req_addr_q[7:INDEX_W]);
    assign hit0_s    = tag_hit(tag_rdata0, req_tag_s);
    assign hit1_s    = tag_hit(tag_rdata1, req_tag_s);

    cache_ctrl_2way_lru #(.INDEX_W(INDEX_W)) u_lru (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (req_idx_s),
        .rd_way  (lru_way_s),
        .upd_en  (lru_upd_en_s),
        .upd_idx (req_idx_s),
        .upd_way (lru_upd_way_s)
    );

    // Victim choice: fill an invalid way first, otherwise follow the LRU bit
    always_comb begin
        if (!valid_q[0]) begin
            victim_s = 1'b0;
        end else if (!valid_q[1]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_way_s;
        end
    end

    // Replacement update: the way just used becomes the one kept
    always_comb begin
        lru_upd_en_s  = 1'b0;
        lru_upd_way_s = 1'b0;
        case (state_q)
            ST_COMPARE: begin
                lru_upd_en_s  = !req_we_q && (hit0_s || hit1_s);
                lru_upd_way_s = hit0_s ? 1'b1 : 1'b0;
            end
            ST_FILL: begin
                lru_upd_en_s  = 1'b1;
                lru_upd_way_s = ~victim_s;
            end
            ST_UPDATE: begin
                lru_upd_en_s  = 1'b1;
                lru_upd_way_s = ~hit_way_q;
            end
            default: begin
                lru_upd_en_s  = 1'b0;
                lru_upd_way_s = 1'b0;
            end
        endcase
    end

    // RAM controls are combinational from state; reset forces them off at once
    always_comb begin
        ram_addr  = {{PAD_W{1'b0}}, req_idx_s};
        ram_r_en  = 1'b0;
        tag_w_en  = 2'b00;
        dat_w_en  = 2'b00;
        tag_wdata = 8'h00;
        dat_wdata = 8'h00;
        if (rst) begin
            ram_addr = 8'h00;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ram_addr = {{PAD_W{1'b0}}, init_cnt_q};
                    tag_w_en = 2'b11;
                end
                ST_LOOKUP: begin
                    ram_r_en = 1'b1;
                end
                ST_FILL: begin
                    tag_w_en[victim_s] = 1'b1;
                    dat_w_en[victim_s] = 1'b1;
                    tag_wdata          = tag_word(req_tag_s);
                    dat_wdata          = fill_data_q;
                end
                ST_UPDATE: begin
                    dat_w_en[hit_way_q] = 1'b1;
                    dat_wdata           = req_wdata_q;
                end
                default: begin
                    ram_r_en = 1'b0;
                end
            endcase
        end
    end

    // Sequencer next-state and registered output computation
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        hit_way_d   = hit_way_q;
        valid_d     = valid_q;
        fill_data_d = fill_data_q;
        res_hit_d   = res_hit_q;
        res_data_d  = res_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + INDEX_W'(1);
                if (init_cnt_q == {INDEX_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                // Tag/data read at the previous negedge are stable here
                valid_d   = {tag_rdata1[VALID_BIT], tag_rdata0[VALID_BIT]};
                hit_way_d = !hit0_s;
                res_hit_d = hit0_s || hit1_s;
                if (hit0_s || hit1_s) begin
                    if (req_we_q) begin
                        state_d = ST_UPDATE;
                    end else begin
                        res_data_d = hit0_s ? dat_rdata0 : dat_rdata1;
                        state_d    = ST_DONE;
                    end
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we_q;
                    mem_addr_d  = req_addr_q;
                    mem_wdata_d = req_wdata_q;
                    state_d     = req_we_q ? ST_MEM_WR : ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (mem_ack) begin
                    fill_data_d = mem_rdata;
                    mem_req_d   = 1'b0;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_FILL: begin
                res_hit_d  = 1'b0;
                res_data_d = fill_data_q;
                state_d    = ST_DONE;
            end
            ST_UPDATE: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = req_addr_q;
                mem_wdata_d = req_wdata_q;
                state_d     = ST_MEM_WR;
            end
            ST_MEM_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // CPU-facing flags are registered; done/hit/rdata publish the result together
        cpu_ready_d = (state_d == ST_IDLE);
        cpu_done_d  = (state_q == ST_DONE);
        if (state_q == ST_DONE) begin
            cpu_hit_d   = res_hit_q;
            cpu_rdata_d = res_data_q;
        end else begin
            cpu_hit_d   = cpu_hit_q;
            cpu_rdata_d = cpu_rdata_q;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 8'h00;
            req_wdata_q <= 8'h00;
            hit_way_q   <= 1'b0;
            valid_q     <= 2'b00;
            fill_data_q <= 8'h00;
            res_hit_q   <= 1'b0;
            res_data_q  <= 8'h00;
            cpu_ready_q <= 1'b0;
            cpu_done_q  <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'h00;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            hit_way_q   <= hit_way_d;
            valid_q     <= valid_d;
            fill_data_q <= fill_data_d;
            res_hit_q   <= res_hit_d;
            res_data_q  <= res_data_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_hit   = cpu_hit_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
